demux_stream_n: RTL and testbench

Registered, handshaked 1-to-N demultiplexer for W-bit data words. Each accepted input word is steered by its accompanying select value into one of N single-entry output registers, each with its own valid/ready handshake. Out-of-range selects are detected, dropped and counted. The block replaces the purely combinational two-way steering stage wherever a downstream consumer can stall.

---
 rtl/demux_stream_n_if.sv | 37 +++
 rtl/demux_stream_n.sv | 98 +++++++++
 tb/tb_demux_stream_n.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_n_if.sv
// Handshake bundle for demux_stream_n: one upstream valid/ready port
// and N downstream valid/ready channels packed side by side.
interface demux_stream_n_if #(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int SEL_W = 4
);
    logic [W-1:0]     input_data;
    logic [SEL_W-1:0] select;
    logic             input_valid;
    logic             input_ready;
    logic [N*W-1:0]   output_data;
    logic [N-1:0]     output_valid;
    logic [N-1:0]     output_ready;

    // Producer of words and consumer of the channels.
    modport master (
        output input_data,
        output select,
        output input_valid,
        output output_ready,
        input  input_ready,
        input  output_data,
        input  output_valid
    );

    // The demultiplexer itself.
    modport slave (
        input  input_data,
        input  select,
        input  input_valid,
        input  output_ready,
        output input_ready,
        output output_data,
        output output_valid
    );
endinterface

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer: each accepted word lands in the
// single-entry register of its selected channel; bad selects are dropped and counted.
module demux_stream_n #(
    parameter int W         = 16,
    parameter int N         = 4,
    parameter int SEL_W     = 4,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_stream_n_if.slave   s,
    input  logic              err_clear,
    output logic [7:0]        drop_count,
    output logic              sel_error
);

    logic [N-1:0][W-1:0] data_q;
    logic [N-1:0][W-1:0] data_d;
    logic [N-1:0]        valid_q;
    logic [N-1:0]        valid_d;
    logic [N-1:0]        sel_hit;
    logic                sel_ok;
    logic                accept;
    logic                bad_xfer;
    logic [7:0]          drop_q;
    logic [7:0]          drop_d;
    logic                sel_err_q;
    logic                sel_err_d;

    // One-hot decode of the select; an all-zero result marks an out-of-range select,
    // which avoids ever indexing a channel vector with an illegal value.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N; k++) begin
            sel_hit[k] = (s.select == SEL_W'(k));
        end
    end

    assign sel_ok = |sel_hit;

    // Ready looks only at the addressed channel, so a stalled channel never blocks others.
    assign s.input_ready = !sel_ok || |(sel_hit & (~valid_q | s.output_ready));
    assign accept        = s.input_valid && s.input_ready;
    assign bad_xfer      = s.input_valid && !sel_ok;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < N; k++) begin
            if (accept && sel_hit[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = s.input_data;
            end else if (valid_q[k] && s.output_ready[k]) begin
                valid_d[k] = 1'b0;
                if (ZERO_IDLE) begin
                    data_d[k] = '0;
                end
            end
        end
    end

    // A clear coinciding with a bad transfer leaves exactly that one drop recorded.
    always_comb begin
        drop_d    = drop_q;
        sel_err_d = sel_err_q;
        if (err_clear) begin
            drop_d    = bad_xfer ? 8'd1 : 8'd0;
            sel_err_d = bad_xfer;
        end else if (bad_xfer) begin
            sel_err_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // NOTE: the data registers are reset too, because output_data must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            data_q    <= '0;
            drop_q    <= 8'd0;
            sel_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign s.output_data  = data_q;
    assign s.output_valid = valid_q;
    assign drop_count     = drop_q;
    assign sel_error      = sel_err_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Scoreboard bench for demux_stream_n: a 4-channel zeroing instance with a per-channel
// expected-word queue, plus a 3-channel instance and a non-zeroing instance.
module tb_demux_stream_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    demux_stream_n_if #(.W(16), .N(4), .SEL_W(4)) m4 ();
    demux_stream_n_if #(.W(16), .N(3), .SEL_W(2)) m3 ();
    demux_stream_n_if #(.W(16), .N(4), .SEL_W(4)) mz ();

    logic [7:0] drop4, drop3, dropz;
    logic       sel4, sel3, selz;
    logic       clr4, clr3, clrz;

    demux_stream_n #(.W(16), .N(4), .SEL_W(4), .ZERO_IDLE(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s(m4.slave),
        .err_clear(clr4), .drop_count(drop4), .sel_error(sel4)
    );
    demux_stream_n #(.W(16), .N(3), .SEL_W(2), .ZERO_IDLE(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .s(m3.slave),
        .err_clear(clr3), .drop_count(drop3), .sel_error(sel3)
    );
    demux_stream_n #(.W(16), .N(4), .SEL_W(4), .ZERO_IDLE(1'b0)) u_dutz (
        .clk(clk), .rst_n(rst_n), .s(mz.slave),
        .err_clear(clrz), .drop_count(dropz), .sel_error(selz)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected words per channel of the 4-channel instance, in acceptance order.
    logic [15:0] q0[$], q1[$], q2[$], q3[$];

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [15:0] q_front(input int k);
        case (k)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    function automatic void q_push(input int k, input logic [15:0] d);
        case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endfunction

    function automatic void q_pop(input int k);
        case (k)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endfunction

    function automatic void q_flush();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endfunction

    // Monitor: an empty queue means the channel must be idle and zeroed; otherwise it must
    // present the front word, which is retired when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (q_size(k) == 0) begin
                    check($sformatf("ch%0d_idle_valid", k), 64'(m4.output_valid[k]), 64'd0);
                    check($sformatf("ch%0d_idle_data", k), 64'(m4.output_data[k*16 +: 16]), 64'd0);
                end else begin
                    check($sformatf("ch%0d_word_valid", k), 64'(m4.output_valid[k]), 64'd1);
                    check($sformatf("ch%0d_word_data", k), 64'(m4.output_data[k*16 +: 16]),
                          64'(q_front(k)));
                    if (m4.output_valid[k] && m4.output_ready[k]) q_pop(k);
                end
            end
        end
    end

    int bad3 = 0;
    always @(negedge clk) begin
        if (rst_n && m3.output_valid != 3'b000) bad3++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word to the 4-channel instance; called and returns at posedge+1.
    task automatic send4(input logic [3:0] sel, input logic [15:0] d, input bit must_be_ready);
        int waited = 0;
        bit seen = 1'b0;
        m4.select      = sel;
        m4.input_data  = d;
        m4.input_valid = 1'b1;
        @(negedge clk);
        if (must_be_ready) check("in_ready_now", 64'(m4.input_ready), 64'd1);
        while (!m4.input_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        seen = m4.input_ready;
        if (!seen) check("in_ready_timeout", 64'(seen), 64'd1);
        @(posedge clk);
        if (seen && sel < 4'd4) q_push(int'(sel), d);
        #1 m4.input_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int nr3 = 0;
        rst_n = 1'b0;
        clr4 = 1'b0; clr3 = 1'b0; clrz = 1'b0;
        m4.input_valid = 1'b0; m4.select = '0; m4.input_data = '0; m4.output_ready = 4'b1111;
        m3.input_valid = 1'b0; m3.select = '0; m3.input_data = '0; m3.output_ready = 3'b111;
        mz.input_valid = 1'b0; mz.select = '0; mz.input_data = '0; mz.output_ready = 4'b0000;
        #3;
        check("por_valid", 64'(m4.output_valid), 64'd0);
        check("por_drop", 64'(drop4), 64'd0);
        check("por_sel_err", 64'(sel4), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Streaming into all four channels on consecutive cycles.
        for (int i = 0; i < 4; i++) send4(4'(i), 16'hA000 + 16'(i), 1'b1);
        repeat (2) tick();

        // Out-of-range selects on the 4-channel instance.
        send4(4'd5, 16'hDEAD, 1'b1);
        check("bad5_drop", 64'(drop4), 64'd1);
        check("bad5_sel_err", 64'(sel4), 64'd1);
        send4(4'd15, 16'hBEEF, 1'b1);
        check("bad15_drop", 64'(drop4), 64'd2);
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        check("clr4_drop", 64'(drop4), 64'd0);
        check("clr4_sel_err", 64'(sel4), 64'd0);

        // Channel 1 stalled and full; channel 3 still accepts; then back-pressure on channel 1.
        m4.output_ready[1] = 1'b0;
        send4(4'd1, 16'h1111, 1'b1);
        send4(4'd3, 16'h3333, 1'b1);
        check("ch1_kept", 64'(m4.output_data[31:16]), 64'h1111);
        m4.select = 4'd1; m4.input_data = 16'h2222; m4.input_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(m4.input_ready), 64'd0);
            tick();
        end
        m4.output_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_ready_high", 64'(m4.input_ready), 64'd1);
        @(posedge clk);
        q_push(1, 16'h2222);
        #1 m4.input_valid = 1'b0;
        check("bp_valid_kept", 64'(m4.output_valid[1]), 64'd1);
        check("bp_data_replaced", 64'(m4.output_data[31:16]), 64'h2222);
        repeat (2) tick();

        // Non-zeroing instance keeps the last word after draining.
        mz.select = 4'd0; mz.input_data = 16'hBEEF; mz.input_valid = 1'b1;
        tick();
        mz.input_valid = 1'b0;
        check("z0_loaded_valid", 64'(mz.output_valid[0]), 64'd1);
        check("z0_loaded_data", 64'(mz.output_data[15:0]), 64'hBEEF);
        mz.output_ready[0] = 1'b1;
        tick();
        mz.output_ready[0] = 1'b0;
        check("z0_drained_valid", 64'(mz.output_valid[0]), 64'd0);
        check("z0_drained_data", 64'(mz.output_data[15:0]), 64'hBEEF);

        // 300 bad selects into the 3-channel instance.
        m3.select = 2'd3; m3.input_data = 16'h0300; m3.input_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!m3.input_ready) nr3++;
            tick();
            m3.input_data = m3.input_data + 16'd1;
            if (i == 0) begin
                check("n3_first_drop", 64'(drop3), 64'd1);
                check("n3_first_sel_err", 64'(sel3), 64'd1);
            end
            if (i == 253) check("n3_drop_254", 64'(drop3), 64'd254);
            if (i == 254) check("n3_drop_255", 64'(drop3), 64'd255);
        end
        m3.input_valid = 1'b0;
        check("n3_never_stalled", 64'(nr3), 64'd0);
        check("n3_no_valid", 64'(bad3), 64'd0);
        check("n3_drop_sat", 64'(drop3), 64'd255);
        check("n3_sel_err", 64'(sel3), 64'd1);
        clr3 = 1'b1;
        tick();
        clr3 = 1'b0;
        check("n3_clr_drop", 64'(drop3), 64'd0);
        check("n3_clr_sel_err", 64'(sel3), 64'd0);
        m3.input_valid = 1'b1;
        repeat (2) tick();
        m3.input_valid = 1'b0;
        check("n3_two_drops", 64'(drop3), 64'd2);
        clr3 = 1'b1; m3.input_valid = 1'b1;
        tick();
        clr3 = 1'b0; m3.input_valid = 1'b0;
        check("n3_clr_bad_drop", 64'(drop3), 64'd1);
        check("n3_clr_bad_sel_err", 64'(sel3), 64'd1);
        tick();
        check("n3_idle_drop", 64'(drop3), 64'd1);

        // Asynchronous reset with words parked in channels 0 and 2.
        m4.output_ready = 4'b1010;
        send4(4'd0, 16'h0C00, 1'b1);
        send4(4'd2, 16'h0C02, 1'b1);
        send4(4'd6, 16'h0BAD, 1'b1);
        check("pre_rst_drop", 64'(drop4), 64'd1);
        check("pre_rst_valid", 64'(m4.output_valid), 64'b0101);
        #1 rst_n = 1'b0;
        q_flush();
        #1;
        check("rst_valid", 64'(m4.output_valid), 64'd0);
        check("rst_data", m4.output_data, 64'd0);
        check("rst_drop", 64'(drop4), 64'd0);
        check("rst_sel_err", 64'(sel4), 64'd0);
        check("rst_z_data", mz.output_data, 64'd0);
        m4.select = 4'd2;
        #0;
        #1;
        check("rst_ready_rule", 64'(m4.input_ready), 64'd1);
        m4.select = 4'd0; m4.input_data = 16'h5A5A; m4.input_valid = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk);
        q_push(0, 16'h5A5A);
        #1 m4.input_valid = 1'b0;
        check("post_rst_valid", 64'(m4.output_valid[0]), 64'd1);
        check("post_rst_data", 64'(m4.output_data[15:0]), 64'h5A5A);
        m4.output_ready = 4'b1111;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
